proj_to_affine: RTL and testbench

// - Consumes the projective (X:Y:Z) result of the scalar multiplier and returns affine x=X/Z, y=Y/Z mod p, p=2^255-19.
// - Computes Z^-1 by Fermat inversion (Z^(p-2)) using square-and-multiply, then multiplies X and Y by Z^-1.
// - Sits directly downstream of the scalar multiplier: its i_x/i_y/i_z/i_start connect to the multiplier's o_x/o_y/o_z/o_finished.

---
 rtl/ed25519_pkg.sv | 39 +++
 rtl/proj_to_affine_if.sv | 37 +++
 rtl/mul_p25519.sv | 62 ++++++
 rtl/proj_to_affine.sv | 166 ++++++++++++++++
 tb/tb_proj_to_affine.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/ed25519_pkg.sv
// Shared definitions for the Curve25519 field-arithmetic blocks.
//   FE_W      : field element width (255)
//   P         : field prime 2^255-19
//   P_MINUS_2 : Fermat inversion exponent
//   p2a_state_t : proj_to_affine FSM states
//   mul_step  : one digit step of the MSB-first digit-serial modular multiply
package ed25519_pkg;

    localparam int FE_W    = 255;
    localparam int DIG_W   = 32;    // multiplier digit width
    localparam int N_DIG   = 8;     // 8 x 32 = 256 >= FE_W
    localparam int EXP_TOP = 253;   // bit 254 of the exponent is consumed by acc = Z

    localparam logic [FE_W-1:0] P =
        255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
    localparam logic [FE_W-1:0] P_MINUS_2 =
        255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffeb;

    typedef enum logic [2:0] {S_IDLE, S_SQR, S_MULZ, S_MULX, S_MULY} p2a_state_t;

    // Returns (r * 2^DIG_W + a * d) mod p for r, a < p. The sum is folded
    // twice using 2^255 = 19 (mod p); after the second fold the value is
    // below 2^255 = p + 19, so a single conditional subtract makes it canonical.
    function automatic logic [FE_W-1:0] mul_step(
        input logic [FE_W-1:0]  r,
        input logic [FE_W-1:0]  a,
        input logic [DIG_W-1:0] d
    );
        logic [FE_W+DIG_W:0] v;
        logic [FE_W:0]       t;
        logic [FE_W-1:0]     u;
        v = {1'b0, r, {DIG_W{1'b0}}} + ({{(DIG_W+1){1'b0}}, a} * {{(FE_W+1){1'b0}}, d});
        t = {1'b0, v[FE_W-1:0]} + (FE_W+1)'(v[FE_W+DIG_W:FE_W]) * (FE_W+1)'(19);
        u = t[FE_W-1:0] + (t[FE_W] ? FE_W'(19) : FE_W'(0));
        if (u >= P) u = u - P;
        return u;
    endfunction

endpackage

// File: rtl/proj_to_affine_if.sv
// Bus between the scalar multiplier (master) and proj_to_affine (slave).
//   i_start          : start pulse from the producer
//   i_x/i_y/i_z      : projective coordinates, each < p
//   o_x/o_y          : affine result, canonical
//   o_busy/o_finished: conversion status / one-cycle completion pulse
//   o_zero           : Z==0 flag, present only when P2A_ZCHECK_EN is defined
interface proj_to_affine_if #(
    parameter int W = 255
);
    logic         i_start;
    logic [W-1:0] i_x;
    logic [W-1:0] i_y;
    logic [W-1:0] i_z;
    logic [W-1:0] o_x;
    logic [W-1:0] o_y;
    logic         o_busy;
    logic         o_finished;
`ifdef P2A_ZCHECK_EN
    logic         o_zero;
`endif

    modport master (
        output i_start, i_x, i_y, i_z,
        input  o_x, o_y, o_busy, o_finished
`ifdef P2A_ZCHECK_EN
        , input o_zero
`endif
    );

    modport slave (
        input  i_start, i_x, i_y, i_z,
        output o_x, o_y, o_busy, o_finished
`ifdef P2A_ZCHECK_EN
        , output o_zero
`endif
    );
endinterface

// File: rtl/mul_p25519.sv
// Modular multiplier r = a*b mod p, p = 2^255-19, result always canonical.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_start        : accepted when idle; operands are latched
//   i_a, i_b       : operands, < p
//   o_r            : result, valid from the o_done cycle until the next start
//   o_done         : one-cycle completion pulse
// Latency is data dependent: a zero operand finishes in one cycle, otherwise
// b is consumed MSB-first one 32-bit digit per cycle (8 cycles).
module mul_p25519
    import ed25519_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [FE_W-1:0] i_a,
    input  logic [FE_W-1:0] i_b,
    output logic [FE_W-1:0] o_r,
    output logic            o_done
);

    logic [FE_W-1:0]          a_q;
    logic [N_DIG*DIG_W-1:0]   b_q;
    logic [FE_W-1:0]          r_q;
    logic [$clog2(N_DIG)-1:0] dig_q;
    logic                     busy_q;
    logic                     done_q;

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
            dig_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_start && !busy_q) begin
                a_q   <= i_a;
                b_q   <= {1'b0, i_b};
                r_q   <= '0;
                dig_q <= '1;
                if (i_a == '0 || i_b == '0) done_q <= 1'b1;
                else                        busy_q <= 1'b1;
            end else if (busy_q) begin
                r_q   <= mul_step(r_q, a_q, b_q[N_DIG*DIG_W-1 -: DIG_W]);
                b_q   <= b_q << DIG_W;
                dig_q <= dig_q - 1'b1;
                if (dig_q == '0) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign o_r    = r_q;
    assign o_done = done_q;

endmodule

// File: rtl/proj_to_affine.sv
// Projective (X:Y:Z) to affine (x, y) = (X/Z, Y/Z) mod 2^255-19.
// Z^-1 is computed as Z^(p-2) by left-to-right square-and-multiply on a
// single shared mul_p25519, then X and Y are multiplied by it.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : i_start, i_x/i_y/i_z in; o_x/o_y, o_busy, o_finished out
// Optional feature macro P2A_ZCHECK_EN: a Z==0 request skips the inversion,
// returns x=y=0 two cycles after start and raises bus.o_zero.
module proj_to_affine
    import ed25519_pkg::*;
#(
    parameter int W     = FE_W,
    parameter int CNT_W = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    proj_to_affine_if.slave bus
);

    p2a_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     x_q, x_d, y_q, y_d, z_q, z_d, acc_q, acc_d;
    logic [W-1:0]     ox_q, ox_d, oy_q, oy_d;
    logic             fin_q, fin_d;
    logic             issued_q, issued_d;   // a multiplier op is in flight

    logic             mul_start, mul_done, op_done, skip;
    logic [W-1:0]     mul_a, mul_b, mul_r;

`ifdef P2A_ZCHECK_EN
    logic zero_q, zero_d;
    assign skip       = (state_q == S_MULY) && zero_q;
    assign bus.o_zero = zero_q;
`else
    assign skip = 1'b0;
`endif

    // Every non-idle state issues exactly one op and advances on its done.
    assign mul_start = (state_q != S_IDLE) && !issued_q && !skip;
    assign op_done   = issued_q && mul_done;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        acc_d    = acc_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        fin_d    = 1'b0;
        issued_d = mul_start ? 1'b1 : (op_done ? 1'b0 : issued_q);
        mul_a    = acc_q;
        mul_b    = acc_q;
`ifdef P2A_ZCHECK_EN
        zero_d   = zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    x_d      = bus.i_x;
                    y_d      = bus.i_y;
                    z_d      = bus.i_z;
                    acc_d    = bus.i_z;
                    cnt_d    = CNT_W'(EXP_TOP);
                    issued_d = 1'b0;
                    state_d  = S_SQR;
`ifdef P2A_ZCHECK_EN
                    zero_d   = (bus.i_z == '0);
                    if (bus.i_z == '0) state_d = S_MULY;
`endif
                end
            end
            S_SQR: begin
                if (op_done) begin
                    acc_d = mul_r;
                    if (P_MINUS_2[cnt_q])   state_d = S_MULZ;
                    else if (cnt_q == '0)   state_d = S_MULX;
                    else                    cnt_d   = cnt_q - 1'b1;
                end
            end
            S_MULZ: begin
                mul_b = z_q;
                if (op_done) begin
                    acc_d = mul_r;
                    if (cnt_q == '0) begin
                        state_d = S_MULX;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        state_d = S_SQR;
                    end
                end
            end
            S_MULX: begin
                mul_a = x_q;
                if (op_done) begin
                    ox_d    = mul_r;
                    state_d = S_MULY;
                end
            end
            S_MULY: begin
                mul_a = y_q;
                if (skip) begin
                    ox_d    = '0;
                    oy_d    = '0;
                    fin_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (op_done) begin
                    oy_d    = mul_r;
                    fin_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            acc_q    <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            fin_q    <= 1'b0;
            issued_q <= 1'b0;
`ifdef P2A_ZCHECK_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            acc_q    <= acc_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            fin_q    <= fin_d;
            issued_q <= issued_d;
`ifdef P2A_ZCHECK_EN
            zero_q   <= zero_d;
`endif
        end
    end

    mul_p25519 u_mul (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (mul_start),
        .i_a     (mul_a),
        .i_b     (mul_b),
        .o_r     (mul_r),
        .o_done  (mul_done)
    );

    assign bus.o_x        = ox_q;
    assign bus.o_y        = oy_q;
    assign bus.o_busy     = (state_q != S_IDLE);
    assign bus.o_finished = fin_q;

endmodule

// File: tb/tb_proj_to_affine.sv
// Self-checking bench for proj_to_affine: expected results are pushed to a
// scoreboard when a conversion is started and compared at o_finished.
// Build with or without P2A_ZCHECK_EN; the Z==0 expectations follow the macro.
module tb_proj_to_affine;

    localparam logic [254:0] P_REF =
        255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
    localparam int BUDGET = 7000;

    typedef struct {
        logic [254:0] x;
        logic [254:0] y;
        logic         zero;
        int           ops;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    proj_to_affine_if #(.W(255)) bus ();

    proj_to_affine dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Multiplier completions observed on the opposite clock edge.
    always @(negedge clk) if (dut.mul_done) done_cnt++;

    task automatic check(input string tag, input logic [254:0] got, input logic [254:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Golden field arithmetic: plain wide multiply and remainder.
    function automatic logic [254:0] gmul(input logic [254:0] a, input logic [254:0] b);
        logic [509:0] pr;
        pr = 510'(a) * 510'(b);
        return 255'(pr % 510'(P_REF));
    endfunction

    // Right-to-left exponentiation, independent of the DUT's bit order.
    function automatic logic [254:0] ginv(input logic [254:0] z);
        logic [254:0] e, r, b;
        e = P_REF - 255'd2;
        r = 255'd1;
        b = z;
        for (int i = 0; i < 255; i++) begin
            if (e[i]) r = gmul(r, b);
            b = gmul(b, b);
        end
        return r;
    endfunction

    function automatic logic [254:0] rand_fe();
        logic [255:0] v;
        logic [254:0] r;
        v = '0;
        for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom())};
        r = v[254:0];
        if (r >= P_REF) r = r - P_REF;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge where o_finished is seen,
    // so a following call starts back-to-back with the finished cycle.
    task automatic run_conv(input string tag,
                            input logic [254:0] x, input logic [254:0] y, input logic [254:0] z,
                            input logic [254:0] ex, input logic [254:0] ey,
                            input logic ez, input int ops, input bit rep);
        exp_t e;
        int   lat;
        bit   seen;
        sb.push_back('{x: ex, y: ey, zero: ez, ops: ops});
        bus.i_start = 1'b1;
        bus.i_x     = x;
        bus.i_y     = y;
        bus.i_z     = z;
        done_cnt    = 0;
        @(negedge clk);
        bus.i_start = 1'b0;
        check({tag, "_busy"}, 255'(bus.o_busy), 255'(1));
        check({tag, "_fin_low"}, 255'(bus.o_finished), 255'(0));
        lat  = 1;
        seen = 0;
        for (int i = 0; i < BUDGET; i++) begin
            if (bus.o_finished) begin
                seen = 1;
                break;
            end
            if (rep && (i == 5 || i == 200)) begin
                bus.i_start = 1'b1;
                bus.i_x     = rand_fe();
                bus.i_y     = rand_fe();
                bus.i_z     = rand_fe();
            end else begin
                bus.i_start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.i_start = 1'b0;
        check({tag, "_finished_seen"}, 255'(seen), 255'(1));
        e = sb.pop_front();
        if (seen) begin
            check({tag, "_x"}, bus.o_x, e.x);
            check({tag, "_y"}, bus.o_y, e.y);
            check({tag, "_mul_ops"}, 255'(done_cnt), 255'(e.ops));
`ifdef P2A_ZCHECK_EN
            check({tag, "_zero"}, 255'(bus.o_zero), 255'(e.zero));
            if (e.zero) check({tag, "_latency"}, 255'(lat), 255'(2));
`endif
        end
    endtask

    initial begin
        logic [254:0] rx, ry, rz, ex, ey, hold_x;
        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        bus.i_x     = '0;
        bus.i_y     = '0;
        bus.i_z     = '0;
        #12;
        check("rst_x", bus.o_x, 255'(0));
        check("rst_y", bus.o_y, 255'(0));
        check("rst_busy", 255'(bus.o_busy), 255'(0));
        check("rst_fin", 255'(bus.o_finished), 255'(0));
`ifdef P2A_ZCHECK_EN
        check("rst_zero", 255'(bus.o_zero), 255'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with hand-derived results.
        run_conv("z_one", 255'd123, 255'd456, 255'd1, 255'd123, 255'd456, 1'b0, 508, 1'b0);
        @(negedge clk);
        hold_x = 255'd123;
        check("hold_x", bus.o_x, hold_x);
        check("fin_pulse", 255'(bus.o_finished), 255'(0));
        run_conv("z_two", 255'd2, 255'd4, 255'd2, 255'd1, 255'd2, 1'b0, 508, 1'b0);
        run_conv("z_pm1", 255'd5, 255'd7, P_REF - 255'd1, P_REF - 255'd5, P_REF - 255'd7,
                 1'b0, 508, 1'b0);
`ifdef P2A_ZCHECK_EN
        run_conv("z_zero", 255'd9, 255'd11, 255'd0, 255'd0, 255'd0, 1'b1, 0, 1'b0);
`else
        run_conv("z_zero", 255'd9, 255'd11, 255'd0, 255'd0, 255'd0, 1'b0, 508, 1'b0);
`endif

        // Random cases against the golden model, back-to-back; the last one
        // also repeats i_start while busy.
        for (int k = 0; k < 3; k++) begin
            rx = rand_fe();
            ry = rand_fe();
            rz = rand_fe();
            ex = gmul(rx, ginv(rz));
            ey = gmul(ry, ginv(rz));
            run_conv((k == 2) ? "rnd_rep" : "rnd", rx, ry, rz, ex, ey, 1'b0, 508, (k == 2));
        end

        // Reset in the middle of the inversion, then a fresh conversion.
        bus.i_start = 1'b1;
        bus.i_x     = 255'd77;
        bus.i_y     = 255'd88;
        bus.i_z     = 255'd3;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 255'(bus.o_busy), 255'(0));
        check("abort_x", bus.o_x, 255'(0));
        check("abort_y", bus.o_y, 255'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rx = rand_fe();
        ry = rand_fe();
        rz = rand_fe();
        run_conv("post_rst", rx, ry, rz, gmul(rx, ginv(rz)), gmul(ry, ginv(rz)), 1'b0, 508, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
